// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin, LSB first, one full-adder cell and a carry flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] ra, rb, rs;
   logic [CW-1:0]    cnt;
   logic             c, s, cn;
   assign s  = ra[0] ^ rb[0] ^ c;
   assign cn = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               ra    <= a;
               rb    <= b;
               c     <= cin;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               rs  <= {s, rs[WIDTH-1:1]};
               c   <= cn;
               cnt <= cnt + 1'b1;
               // final bit: the completed result goes straight to the output regs
               if (cnt == LAST) begin
                  sum   <= {s, rs[WIDTH-1:1]};
                  cout  <= cn;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf   <= c ^ cn;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
